// File: rtl/dec_serial_error_locator.sv
// Serial DEC error locator: applies the per-bit flip rule LANES positions per
// clock over a captured word and returns the corrected word, flip count and uncorrectable flag.
module dec_serial_error_locator #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LANES   = 8,
  parameter int unsigned MAX_ERR = 2,
  parameter int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_ea,
  input  logic [DATA_W-1:0] in_eb,
  input  logic [DATA_W-1:0] in_ed,
  input  logic              in_deda,
  input  logic              in_dedb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_err_cnt,
  output logic              out_uncorr,
  output logic              busy
);

  localparam int unsigned N     = DATA_W / LANES;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] raw_q, raw_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] ea_q, ea_d, eb_q, eb_d, ed_q, ed_d;
  logic              deda_q, deda_d, dedb_q, dedb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_err_cnt_q, out_err_cnt_d;
  logic              out_uncorr_q, out_uncorr_d;

  logic [LANES-1:0]  flip_c;
  logic [CNT_W-1:0]  pop_c;
  logic              uncorr_c;
  logic [31:0]       shamt_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      raw_q         <= '0;
      work_q        <= '0;
      ea_q          <= '0;
      eb_q          <= '0;
      ed_q          <= '0;
      deda_q        <= 1'b0;
      dedb_q        <= 1'b0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_data_q    <= '0;
      out_err_cnt_q <= '0;
      out_uncorr_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      raw_q         <= raw_d;
      work_q        <= work_d;
      ea_q          <= ea_d;
      eb_q          <= eb_d;
      ed_q          <= ed_d;
      deda_q        <= deda_d;
      dedb_q        <= dedb_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      out_data_q    <= out_data_d;
      out_err_cnt_q <= out_err_cnt_d;
      out_uncorr_q  <= out_uncorr_d;
    end
  end

  // Next-state, scan datapath and registered-output next values
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    raw_d         = raw_q;
    work_d        = work_q;
    ea_d          = ea_q;
    eb_d          = eb_q;
    ed_d          = ed_q;
    deda_d        = deda_q;
    dedb_d        = dedb_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_err_cnt_d = out_err_cnt_q;
    out_uncorr_d  = out_uncorr_q;
    uncorr_c      = 1'b0;
    pop_c         = '0;

    shamt_c = 32'(idx_q) * LANES;
    flip_c  = {LANES{~dedb_q}} &
              ((LANES'(ea_q >> shamt_c) & LANES'(eb_q >> shamt_c)) |
               (LANES'(ed_q >> shamt_c) & {LANES{deda_q}}));
    for (int unsigned j = 0; j < LANES; j++) begin
      pop_c = pop_c + CNT_W'(flip_c[j]);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          raw_d   = in_data;
          work_d  = in_data;
          ea_d    = in_ea;
          eb_d    = in_eb;
          ed_d    = in_ed;
          deda_d  = in_deda;
          dedb_d  = in_dedb;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        work_d = work_q ^ (DATA_W'(flip_c) << shamt_c);
        cnt_d  = cnt_q + pop_c;
        if (idx_q == IDX_LAST) begin
          // Result is latched on the way into DONE so it stays put under backpressure
          uncorr_c      = dedb_q | (cnt_d > MAX_ERR_C);
          out_uncorr_d  = uncorr_c;
          out_err_cnt_d = cnt_d;
          out_data_d    = uncorr_c ? raw_q : work_d;
          state_d       = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_data    = out_data_q;
  assign out_err_cnt = out_err_cnt_q;
  assign out_uncorr  = out_uncorr_q;

endmodule

// File: tb/tb_dec_serial_error_locator.sv
// Directed, table-driven bench for dec_serial_error_locator (DATA_W=32, LANES=8).
module tb_dec_serial_error_locator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data, in_ea, in_eb, in_ed;
  logic        in_deda, in_dedb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_err_cnt;
  logic        out_uncorr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data, ea, eb, ed;
    logic        deda, dedb;
    logic [31:0] exp_data;
    int          exp_cnt;
    logic        exp_uncorr;
  } vec_t;

  vec_t vecs[10];

  dec_serial_error_locator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ea(in_ea), .in_eb(in_eb), .in_ed(in_ed),
    .in_deda(in_deda), .in_dedb(in_dedb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err_cnt(out_err_cnt), .out_uncorr(out_uncorr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_data = v.data; in_ea = v.ea; in_eb = v.eb; in_ed = v.ed;
    in_deda = v.deda; in_dedb = v.dedb;
  endtask

  // Starts and ends at a negedge; word accepted on the posedge in between
  task automatic accept(input vec_t v);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({v.name, " ready_before_accept"}, 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({v.name, " busy_after_accept"}, 32'(busy), 32'd1);
    check({v.name, " ready_low_in_scan"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_out(input string name);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({name, " latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_out(input vec_t v);
    check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, " data"}, out_data, v.exp_data);
    check({v.name, " cnt"}, 32'(out_err_cnt), 32'(v.exp_cnt));
    check({v.name, " uncorr"}, 32'(out_uncorr), 32'(v.exp_uncorr));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"none",      32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 0, 1'b0};
    vecs[1] = '{"single",    32'hDEADBEEF, 32'h20, 32'h20, 32'h0, 1'b0, 1'b0, 32'hDEADBECF, 1, 1'b0};
    vecs[2] = '{"dbl_ed",    32'hDEADBEEF, 32'h0, 32'h0, 32'h80000001, 1'b1, 1'b0, 32'h5EADBEEE, 2, 1'b0};
    vecs[3] = '{"ed_nodeda", 32'hDEADBEEF, 32'h0, 32'h0, 32'h80000001, 1'b0, 1'b0, 32'hDEADBEEF, 0, 1'b0};
    vecs[4] = '{"triple",    32'hDEADBEEF, 32'h00010101, 32'h00010101, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 3, 1'b1};
    vecs[5] = '{"dedb",      32'hDEADBEEF, 32'h8, 32'h8, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 0, 1'b1};
    vecs[6] = '{"or_terms",  32'hDEADBEEF, 32'h100, 32'h100, 32'h100, 1'b1, 1'b0, 32'hDEADBFEF, 1, 1'b0};
    vecs[7] = '{"lane_edge", 32'h00000000, 32'h01000000, 32'h01000000, 32'h00800000, 1'b1, 1'b0, 32'h01800000, 2, 1'b0};
    vecs[8] = '{"and_mask",  32'h12345678, 32'hFFFFFFFF, 32'h0000000F, 32'h0, 1'b0, 1'b0, 32'h12345678, 4, 1'b1};
    vecs[9] = '{"all_flip",  32'hA5A5A5A5, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hA5A5A5A5, 32, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready_idle", 32'(in_ready), 32'd1);
    check("reset data", out_data, 32'd0);
    check("reset cnt", 32'(out_err_cnt), 32'd0);
    check("reset uncorr", 32'(out_uncorr), 32'd0);

    for (int i = 0; i < 10; i++) begin
      accept(vecs[i]);
      wait_out(vecs[i].name);
      check_out(vecs[i]);
      pop();
      check({vecs[i].name, " idle_after_pop"}, 32'(in_ready), 32'd1);
      check({vecs[i].name, " valid_drop"}, 32'(out_valid), 32'd0);
    end

    // Backpressure: word A in DONE, word B offered continuously
    drive(vecs[1]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[2]);
    wait_out("bp_A");
    check_out(vecs[1]);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold ready", 32'(in_ready), 32'd0);
      check("bp hold data", out_data, 32'hDEADBECF);
      check("bp hold cnt", 32'(out_err_cnt), 32'd1);
      check("bp hold busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle ready", 32'(in_ready), 32'd1);
    check("bp idle valid", 32'(out_valid), 32'd0);
    check("bp idle busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp B accepted", 32'(busy), 32'd1);
    wait_out("bp_B");
    check_out(vecs[2]);
    pop();

    // Reset during scan cycle 2
    accept(vecs[4]);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_scan valid", 32'(out_valid), 32'd0);
    check("rst_scan ready", 32'(in_ready), 32'd1);
    check("rst_scan busy", 32'(busy), 32'd0);
    check("rst_scan data", out_data, 32'd0);
    check("rst_scan cnt", 32'(out_err_cnt), 32'd0);
    check("rst_scan uncorr", 32'(out_uncorr), 32'd0);
    @(negedge clk);
    check("rst_held ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    accept(vecs[7]);
    wait_out(vecs[7].name);
    check_out(vecs[7]);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
